// File: rtl/exp_lut_arbiter.sv
// Round-robin arbiter sharing one pipelined exp LUT core among N_REQ requesters.
// Optional grant/stall statistics are built when EXP_ARB_STATS_EN is defined.
module exp_lut_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int LUT_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  output logic                   lut_valid_in,
  output logic [WIDTH-1:0]       lut_a,
  input  logic                   lut_valid_out,
  input  logic [WIDTH-1:0]       lut_result,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   err_tag,
  output logic [N_REQ*16-1:0]    stat_grants,
  output logic [15:0]            stat_stalls
);
  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  ptr_r;
  logic [ID_W:0]    cand_s;
  logic             found_s;
  logic [ID_W-1:0]  grant_id_s;
  logic [N_REQ-1:0] grant_s;
  logic [WIDTH-1:0] operand_s;
  logic             lut_valid_in_r;
  logic [WIDTH-1:0] lut_a_r;
  logic [ID_W-1:0]  issue_id_r;
  logic             tag_v_r  [LUT_LAT];
  logic [ID_W-1:0]  tag_id_r [LUT_LAT];
  logic             head_v_s;
  logic [ID_W-1:0]  head_id_s;
  logic [N_REQ-1:0] rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             err_tag_r;

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id == ID_W'(i)) oh[i] = 1'b1;
      else                oh[i] = 1'b0;
    end
    return oh;
  endfunction

  // Rotating search: first valid lane at or after the pointer, wrapping at N_REQ.
  always_comb begin
    cand_s     = '0;
    found_s    = 1'b0;
    grant_id_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = {1'b0, ptr_r} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(N_REQ)) cand_s = cand_s - (ID_W+1)'(N_REQ);
      else                             cand_s = cand_s;
      if (!found_s && req_valid[cand_s[ID_W-1:0]]) begin
        found_s    = 1'b1;
        grant_id_s = cand_s[ID_W-1:0];
      end else begin
        found_s    = found_s;
        grant_id_s = grant_id_s;
      end
    end
  end

  // Decode the winner into a ready vector and select its operand.
  always_comb begin
    grant_s   = '0;
    operand_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (found_s && (grant_id_s == ID_W'(i))) begin
        grant_s[i] = 1'b1;
        operand_s  = req_x[i*WIDTH +: WIDTH];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  assign req_ready = grant_s;

  // Issue stage and pointer advance; lut_a and the tag hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r          <= '0;
      lut_valid_in_r <= 1'b0;
      lut_a_r        <= '0;
      issue_id_r     <= '0;
    end else begin
      lut_valid_in_r <= found_s;
      if (found_s) begin
        lut_a_r    <= operand_s;
        issue_id_r <= grant_id_s;
        ptr_r      <= (grant_id_s == ID_W'(N_REQ-1)) ? '0 : grant_id_s + ID_W'(1);
      end
    end
  end

  // Tag pipe tracks the core latency so the head lines up with lut_valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LUT_LAT; s++) begin
        tag_v_r[s]  <= 1'b0;
        tag_id_r[s] <= '0;
      end
    end else begin
      tag_v_r[0]  <= lut_valid_in_r;
      tag_id_r[0] <= issue_id_r;
      for (int s = 1; s < LUT_LAT; s++) begin
        tag_v_r[s]  <= tag_v_r[s-1];
        tag_id_r[s] <= tag_id_r[s-1];
      end
    end
  end

  assign head_v_s  = tag_v_r[LUT_LAT-1];
  assign head_id_s = tag_id_r[LUT_LAT-1];

  // Return stage; a strobe disagreement drops the slot and latches the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      err_tag_r   <= 1'b0;
    end else begin
      if (head_v_s && lut_valid_out) begin
        rsp_valid_r <= id_onehot(head_id_s);
        rsp_data_r  <= lut_result;
      end else begin
        rsp_valid_r <= '0;
      end
      if (head_v_s != lut_valid_out) err_tag_r <= 1'b1;
    end
  end

  assign lut_valid_in = lut_valid_in_r;
  assign lut_a        = lut_a_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign err_tag      = err_tag_r;

`ifdef EXP_ARB_STATS_EN
  logic [15:0] grants_r [N_REQ];
  logic [15:0] stalls_r;
  logic        stall_s;

  assign stall_s = |(req_valid & ~grant_s);

  // Saturating per-lane grant counters and a shared contention counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) grants_r[i] <= 16'h0000;
      stalls_r <= 16'h0000;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_s[i] && req_valid[i] && (grants_r[i] != 16'hFFFF))
          grants_r[i] <= grants_r[i] + 16'h0001;
      end
      if (stall_s && (stalls_r != 16'hFFFF)) stalls_r <= stalls_r + 16'h0001;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) stat_grants[i*16 +: 16] = grants_r[i];
  end
  assign stat_stalls = stalls_r;
`else
  assign stat_grants = '0;
  assign stat_stalls = 16'h0000;
`endif

endmodule

// File: tb/tb_exp_lut_arbiter.sv
// Self-checking bench for exp_lut_arbiter: round-robin model, 1-cycle LUT stub,
// response scoreboard compared by lane, data and arrival cycle.
module tb_exp_lut_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [127:0] req_x;
  logic        lut_valid_in;
  logic [31:0] lut_a;
  logic        lut_valid_out;
  logic [31:0] lut_result;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        err_tag;
  logic [63:0] stat_grants;
  logic [15:0] stat_stalls;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] cyc;
  } rsp_t;

  rsp_t        obs_q[$];
  rsp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mptr = 0;
  int          mgr [4];
  int          mstall = 0;
  logic [31:0] lane_x [4];
  logic        force_v;
  logic        mv_r;
  logic [31:0] mr_r;

  exp_lut_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .lut_valid_in(lut_valid_in), .lut_a(lut_a),
    .lut_valid_out(lut_valid_out), .lut_result(lut_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_tag(err_tag),
    .stat_grants(stat_grants), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lut_f(input logic [31:0] x);
    return {x[7:0], x[31:8]} ^ 32'h3C3C_A5A5;
  endfunction

  // Stand-in exp LUT core with one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_r <= 1'b0;
      mr_r <= 32'h0;
    end else begin
      mv_r <= lut_valid_in;
      mr_r <= lut_f(lut_a);
    end
  end
  assign lut_valid_out = mv_r | force_v;
  assign lut_result    = mr_r;

  task automatic tick();
    rsp_t o;
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_valid !== 4'b0000) begin
      o.mask = rsp_valid; o.data = rsp_data; o.cyc = 32'(cyc);
      obs_q.push_back(o);
    end
  endtask

  task automatic drive(input logic [3:0] pat);
    req_valid = pat;
    for (int i = 0; i < 4; i++) req_x[i*32 +: 32] = lane_x[i];
    #1;
  endtask

  // Reference: first valid lane at or after the pointer wins; result due 3 cycles later.
  task automatic model_accept(input logic [3:0] pat, output logic [3:0] m);
    rsp_t e;
    int l;
    m = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      l = (mptr + k) % 4;
      if (m == 4'b0000 && pat[l]) begin
        m[l] = 1'b1;
        e.mask = m; e.data = lut_f(lane_x[l]); e.cyc = 32'(cyc + 3);
        exp_q.push_back(e);
        mptr = (l + 1) % 4;
        mgr[l]++;
      end
    end
    if ((pat & ~m) != 4'b0000) mstall++;
  endtask

  task automatic do_reset();
    req_valid = 4'b0000; force_v = 1'b0; rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    obs_q.delete(); exp_q.delete();
    mptr = 0; mstall = 0;
    for (int i = 0; i < 4; i++) mgr[i] = 0;
  endtask

  task automatic test_reset();
    req_valid = 4'b0000; force_v = 1'b0; req_x = '0; rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({req_ready, lut_valid_in, lut_a, rsp_valid, rsp_data, err_tag, stat_grants, stat_stalls} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b lvi=%b a=%h rspv=%b rspd=%h err=%b sg=%h ss=%h expected all zero",
               req_ready, lut_valid_in, lut_a, rsp_valid, rsp_data, err_tag, stat_grants, stat_stalls);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (lut_valid_in !== 1'b0 || rsp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle lvi=%b rspv=%b expected 0 and 0000", lut_valid_in, rsp_valid);
      end
    end
  endtask

  task automatic test_single_lane();
    logic [3:0] m;
    do_reset();
    lane_x[2] = 32'h0000_8000;
    for (int i = 0; i < 4; i++) begin
      drive(4'b0100);
      model_accept(4'b0100, m);
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL single_ready cycle %0d got %b expected 0100", i, req_ready);
      end
      tick();
    end
    drive(4'b0000);
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL single_count got %0d expected 4", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_rsp[%0d] got %b/%h@%0d expected %b/%h@%0d", i, obs_q[i].mask,
                 obs_q[i].data, obs_q[i].cyc, exp_q[i].mask, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] m;
    do_reset();
    for (int i = 0; i < 4; i++) lane_x[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111);
      model_accept(4'b1111, m);
      checks++;
      if (req_ready !== (4'b0001 << (i % 4))) begin
        errors++;
        $display("FAIL fair_order step %0d got %b expected %b", i, req_ready, 4'b0001 << (i % 4));
      end
      tick();
      for (int l = 0; l < 4; l++) if (m[l]) lane_x[l] = $urandom;
    end
    drive(4'b0000);
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL fair_count got %0d expected 8", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fair_rsp[%0d] got %b/%h@%0d expected %b/%h@%0d", i, obs_q[i].mask,
                 obs_q[i].data, obs_q[i].cyc, exp_q[i].mask, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++;
`ifdef EXP_ARB_STATS_EN
    if (stat_grants !== {4{16'd2}} || stat_stalls !== 16'd8) begin
`else
    if (stat_grants !== 64'h0 || stat_stalls !== 16'h0) begin
`endif
      errors++;
      $display("FAIL fair_stats got grants=%h stalls=%0d", stat_grants, stat_stalls);
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] m;
    logic [3:0] want [3];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0001;
    do_reset();
    lane_x[2] = $urandom;
    drive(4'b0100);
    model_accept(4'b0100, m);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011);
      model_accept(4'b0011, m);
      checks++;
      if (req_ready !== want[i]) begin
        errors++;
        $display("FAIL wrap_grant step %0d got %b expected %b", i, req_ready, want[i]);
      end
      tick();
      for (int l = 0; l < 4; l++) if (m[l]) lane_x[l] = $urandom;
    end
    drive(4'b0000);
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 4 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d expected 4", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_rsp[%0d] got %b/%h@%0d expected %b/%h@%0d", i, obs_q[i].mask,
                 obs_q[i].data, obs_q[i].cyc, exp_q[i].mask, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    drive(4'b0000);
    force_v = 1'b1;
    tick();
    force_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (err_tag !== 1'b1 || rsp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL mismatch_hold step %0d got err=%b rspv=%b expected 1 and 0000", i, err_tag, rsp_valid);
      end
      tick();
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (err_tag !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_clear got err=%b expected 0", err_tag);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 4; i++) lane_x[i] = $urandom;
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111);
      tick();
    end
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    obs_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 0 || err_tag !== 1'b0) begin
      errors++;
      $display("FAIL midflight_quiet got %0d responses err=%b expected 0 and 0", obs_q.size(), err_tag);
    end
    drive(4'b1111);
    checks++;
    if (req_ready !== 4'b0001 || stat_stalls !== 16'h0) begin
      errors++;
      $display("FAIL midflight_ptr got ready=%b stalls=%0d expected 0001 and 0", req_ready, stat_stalls);
    end
    drive(4'b0000);
    tick();
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic [3:0] pat;
    do_reset();
    for (int i = 0; i < 4; i++) lane_x[i] = $urandom;
    for (int i = 0; i < 300; i++) begin
      pat = 4'($urandom_range(0, 15));
      drive(pat);
      model_accept(pat, m);
      checks++;
      if (req_ready !== m) begin
        errors++;
        $display("FAIL rand_ready step %0d valid=%b got %b expected %b", i, pat, req_ready, m);
      end
      tick();
      for (int l = 0; l < 4; l++) if (m[l]) lane_x[l] = $urandom;
    end
    drive(4'b0000);
    repeat (6) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_rsp[%0d] got %b/%h@%0d expected %b/%h@%0d", i, obs_q[i].mask,
                 obs_q[i].data, obs_q[i].cyc, exp_q[i].mask, exp_q[i].data, exp_q[i].cyc);
      end
    end
    for (int l = 0; l < 4; l++) begin
      checks++;
`ifdef EXP_ARB_STATS_EN
      if (stat_grants[l*16 +: 16] !== 16'(mgr[l])) begin
`else
      if (stat_grants[l*16 +: 16] !== 16'h0) begin
`endif
        errors++;
        $display("FAIL rand_grants lane %0d got %0d model %0d", l, stat_grants[l*16 +: 16], mgr[l]);
      end
    end
    checks++;
`ifdef EXP_ARB_STATS_EN
    if (stat_stalls !== 16'(mstall)) begin
`else
    if (stat_stalls !== 16'h0) begin
`endif
      errors++;
      $display("FAIL rand_stalls got %0d model %0d", stat_stalls, mstall);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      lane_x[i] = 32'h0;
      mgr[i] = 0;
    end
    test_reset();
    test_single_lane();
    test_fairness();
    test_wrap_skip();
    test_mismatch();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
